uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 106 ++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, held data bus with level ready.
// Ready is cleared only by reset or by a confirmed start bit of the next frame.
module uart_rx #(
    parameter int unsigned CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       ready,
    output logic [7:0] data
);

    localparam int unsigned CntW = $clog2(CLK_PER_BIT) + 1;
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic            rx_meta_q, rxs_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            ready_q, ready_d;
    logic [7:0]      data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ready_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ready_d = ready_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs_q) state_d = StStart;
            end
            StStart: begin
                // Mid-start sample: a high line here means the low level was a glitch.
                if (cnt_q == HalfM1) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        ready_d = 1'b0;
                        bit_d   = '0;
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == FullM1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs_q;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                // Leaving at mid-stop lets a start bit directly after the stop bit be caught.
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rxs_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ready = ready_q;
    assign data  = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: byte sweep, back-to-back, glitch, framing error and reset cases.
module tb_uart_rx;

    localparam int unsigned Cpb = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       ready;
    logic [7:0] data;

    int vectors = 0;
    int errors  = 0;

    uart_rx #(.CLK_PER_BIT(Cpb)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .ready (ready),
        .data  (data)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0, Cpb);
        for (int i = 0; i < 8; i++) send_bit(b[i], Cpb);
        send_bit(stop, Cpb);
    endtask

    task automatic test_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", ready);
        end
        vectors++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", data);
        end
        send_bit(1'b1, 5 * Cpb);
        vectors++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_ready: got %b want 0", ready);
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 256; k++) begin
            send_frame(8'(k), 1'b1);
            send_bit(1'b1, Cpb);
            vectors++;
            if (ready !== 1'b1 || data !== 8'(k)) begin
                errors++;
                $display("FAIL sweep k=%0d: got ready=%b data=%h want ready=1 data=%h",
                         k, ready, data, 8'(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        send_frame(8'hA5, 1'b1);
        vectors++;
        if (ready !== 1'b1 || data !== 8'hA5) begin
            errors++;
            $display("FAIL b2b_first: got ready=%b data=%h want ready=1 data=a5", ready, data);
        end
        send_bit(1'b0, 4);
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_early_start: got ready=%b want 1", ready);
        end
        send_bit(1'b0, Cpb - 4);
        vectors++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_mid_start_clear: got ready=%b want 0", ready);
        end
        b = 8'h3C;
        for (int i = 0; i < 8; i++) send_bit(b[i], Cpb);
        send_bit(1'b1, Cpb);
        send_bit(1'b1, Cpb);
        vectors++;
        if (ready !== 1'b1 || data !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_second: got ready=%b data=%h want ready=1 data=3c", ready, data);
        end
    endtask

    task automatic test_glitch();
        send_frame(8'h55, 1'b1);
        send_bit(1'b1, Cpb);
        vectors++;
        if (ready !== 1'b1 || data !== 8'h55) begin
            errors++;
            $display("FAIL glitch_pre: got ready=%b data=%h want ready=1 data=55", ready, data);
        end
        send_bit(1'b0, 5);
        send_bit(1'b1, 2 * Cpb);
        vectors++;
        if (ready !== 1'b1 || data !== 8'h55) begin
            errors++;
            $display("FAIL glitch_hold: got ready=%b data=%h want ready=1 data=55", ready, data);
        end
        send_frame(8'hF0, 1'b1);
        send_bit(1'b1, Cpb);
        vectors++;
        if (ready !== 1'b1 || data !== 8'hF0) begin
            errors++;
            $display("FAIL glitch_next: got ready=%b data=%h want ready=1 data=f0", ready, data);
        end
    endtask

    task automatic test_framing_error();
        send_frame(8'h81, 1'b0);
        send_bit(1'b1, 2 * Cpb);
        vectors++;
        if (ready !== 1'b0 || data !== 8'hF0) begin
            errors++;
            $display("FAIL frame_err: got ready=%b data=%h want ready=0 data=f0", ready, data);
        end
        send_frame(8'h7E, 1'b1);
        send_bit(1'b1, Cpb);
        vectors++;
        if (ready !== 1'b1 || data !== 8'h7E) begin
            errors++;
            $display("FAIL frame_recover: got ready=%b data=%h want ready=1 data=7e", ready, data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hFA;
        send_bit(1'b0, Cpb);
        for (int i = 0; i < 4; i++) send_bit(b[i], Cpb);
        send_bit(b[4], Cpb / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (ready !== 1'b0 || data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid: got ready=%b data=%h want ready=0 data=00", ready, data);
        end
        send_bit(b[4], Cpb / 2 - 1);
        for (int i = 5; i < 8; i++) send_bit(b[i], Cpb);
        send_bit(1'b1, 3 * Cpb);
        vectors++;
        if (ready !== 1'b0 || data !== 8'h00) begin
            errors++;
            $display("FAIL rst_tail_ignored: got ready=%b data=%h want ready=0 data=00",
                     ready, data);
        end
        send_frame(8'hC3, 1'b1);
        send_bit(1'b1, Cpb);
        vectors++;
        if (ready !== 1'b1 || data !== 8'hC3) begin
            errors++;
            $display("FAIL rst_next: got ready=%b data=%h want ready=1 data=c3", ready, data);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sweep();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
